alu_accum_seq: RTL and testbench

Parametrised, sequential successor to the 8-bit accumulator ALU. It holds a WIDTH-bit accumulator and applies one of eight operations with a second operand. Multiply is computed iteratively (shift-add, one bit per cycle), and a start/busy/done handshake is exposed. A four-state power/run/error FSM makes the error state sticky until it is explicitly cleared. The block sits between operand sources and downstream logic that consume `acc` and status.

---
 rtl/alu_accum_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_accum_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_seq.sv
// -----------------------------------------------------------------------------
// alu_accum_seq
//
// Sequential accumulator ALU. A WIDTH-bit accumulator is combined with a
// second operand by one of eight operations. Multiply is an unsigned shift-add
// that takes WIDTH cycles. A four-state OFF/READY/RUN/ERROR FSM sequences the
// work and holds ERROR until an explicit clear.
//
// Configuration macro: ALU_MULT_EN
//   defined   : MUL (op=110) is the iterative shift-add multiplier.
//   undefined : no multiplier logic; MUL spends one RUN cycle, leaves acc
//               unchanged and goes to ERROR.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   on         in   1      power enable; low forces OFF and zeroes acc
//   clear      in   1      acc <= 0 (READY), also leaves ERROR
//   load       in   1      acc <= num1 (READY)
//   start      in   1      begin op with num2 (READY)
//   op         in   3      AND,OR,XOR,NOT,ADD,SUB,MUL,PASS
//   num1       in   WIDTH  load value
//   num2       in   WIDTH  second operand, captured on accepted start
//   acc        out  WIDTH  accumulator
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle pulse on successful completion
//   ovf        out  1      high exactly while in ERROR
//   state      out  2      current state (OFF=0, READY=1, RUN=2, ERROR=3)
//   next_state out  2      combinational next state
// -----------------------------------------------------------------------------
module alu_accum_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             clear,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [1:0]       state,
  output logic [1:0]       next_state
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_opnd;
  logic             r_done;

  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_last;   // RUN completes on this cycle
  logic [WIDTH:0]   w_add;

  assign w_add = {1'b0, r_acc} + {1'b0, r_opnd};

`ifdef ALU_MULT_EN
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;  // acc, shifted left one place per iteration
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_prod_sum;

  // r_opnd is shifted right each iteration, so bit 0 is always the current
  // multiplier bit. On the last iteration this sum is the full product.
  assign w_prod_sum = r_prod + (r_opnd[0] ? r_mcand : '0);
`endif

  // Result and error of the operation in flight.
  always_comb begin
    w_res  = r_acc;
    w_err  = 1'b0;
    w_last = 1'b1;
    case (r_op)
      OP_AND:  w_res = r_acc & r_opnd;
      OP_OR:   w_res = r_acc | r_opnd;
      OP_XOR:  w_res = r_acc ^ r_opnd;
      OP_NOT:  w_res = ~r_acc;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_err = w_add[WIDTH];
      end
      OP_SUB: begin
        w_res = r_acc - r_opnd;
        w_err = (r_acc < r_opnd);
      end
      OP_MUL: begin
`ifdef ALU_MULT_EN
        w_last = (r_cnt == LAST_ITER);
        w_res  = w_prod_sum[WIDTH-1:0];
        w_err  = |w_prod_sum[2*WIDTH-1:WIDTH];
`else
        w_res  = r_acc;
        w_err  = 1'b1;
`endif
      end
      OP_PASS: w_res = r_opnd;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    if (!on) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:   w_next = S_READY;
        S_READY: if (!clear && !load && start) w_next = S_RUN;
        S_RUN:   if (w_last) w_next = w_err ? S_ERROR : S_READY;
        S_ERROR: if (clear) w_next = S_READY;
      endcase
    end
  end

  // Datapath and state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OFF;
      r_acc   <= '0;
      r_op    <= '0;
      r_opnd  <= '0;
      r_done  <= 1'b0;
`ifdef ALU_MULT_EN
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (!on) begin
        r_acc <= '0;
      end else begin
        case (r_state)
          S_READY: begin
            if (clear) begin
              r_acc <= '0;
            end else if (load) begin
              r_acc <= num1;
            end else if (start) begin
              r_op   <= op;
              r_opnd <= num2;
`ifdef ALU_MULT_EN
              r_prod  <= '0;
              r_mcand <= {{WIDTH{1'b0}}, r_acc};
              r_cnt   <= '0;
`endif
            end
          end
          S_RUN: begin
            if (w_last) begin
              r_acc  <= w_res;
              r_done <= !w_err;
            end
`ifdef ALU_MULT_EN
            else begin
              r_prod  <= w_prod_sum;
              r_mcand <= r_mcand << 1;
              r_opnd  <= r_opnd >> 1;
              r_cnt   <= r_cnt + 1'b1;
            end
`endif
          end
          S_ERROR: begin
            if (clear) r_acc <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign acc        = r_acc;
  assign done       = r_done;
  assign busy       = (r_state == S_RUN);
  assign ovf        = (r_state == S_ERROR);
  assign state      = r_state;
  assign next_state = w_next;

endmodule

// File: tb/tb_alu_accum_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_accum_seq
//
// Bench for alu_accum_seq (WIDTH=8). A behavioural model tracks state, acc and
// the remaining RUN cycles; results come from plain integer arithmetic. A
// compare process checks every output one step after each rising edge.
// Directed scenarios pin expected literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_alu_accum_seq;

  localparam int W = 8;
`ifdef ALU_MULT_EN
  localparam bit MULT = 1'b1;
`else
  localparam bit MULT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         on;
  logic         clear;
  logic         load;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [W-1:0] acc;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [1:0]   state;
  logic [1:0]   next_state;

  int checks = 0;
  int errors = 0;

  alu_accum_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .clear(clear), .load(load),
    .start(start), .op(op), .num1(num1), .num2(num2), .acc(acc),
    .busy(busy), .done(done), .ovf(ovf), .state(state),
    .next_state(next_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int           m_state = 0;   // 0 OFF, 1 READY, 2 RUN, 3 ERROR
  logic [W-1:0] m_acc   = '0;
  bit           m_done  = 1'b0;
  int           m_op    = 0;
  logic [W-1:0] m_b     = '0;
  int           m_left  = 0;   // RUN cycles still to go

  function automatic void eval(input int o, input logic [W-1:0] a,
                               input logic [W-1:0] b,
                               output logic [W-1:0] r, output bit err);
    longint ai = longint'(a);
    longint bi = longint'(b);
    longint full;
    err = 1'b0;
    case (o)
      0: full = ai & bi;
      1: full = ai | bi;
      2: full = ai ^ bi;
      3: full = 255 - ai;
      4: begin full = ai + bi; err = (full > 255); end
      5: begin full = ai - bi; err = (ai < bi); end
      6: begin
        if (MULT) begin full = ai * bi; err = (full > 255); end
        else begin full = ai; err = 1'b1; end
      end
      default: full = bi;
    endcase
    r = full[W-1:0];
  endfunction

  function automatic int exp_next();
    logic [W-1:0] r;
    bit e;
    if (!on) return 0;
    case (m_state)
      0: return 1;
      1: return (!clear && !load && start) ? 2 : 1;
      2: begin
        if (m_left != 1) return 2;
        eval(m_op, m_acc, m_b, r, e);
        return e ? 3 : 1;
      end
      default: return clear ? 1 : 3;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_acc = '0; m_done = 1'b0; m_left = 0;
        m_op = 0; m_b = '0;
      end else begin
        int ns;
        logic [W-1:0] r;
        bit e;
        ns = exp_next();
        m_done = 1'b0;
        if (!on) begin
          m_acc = '0;
        end else begin
          case (m_state)
            1: begin
              if (clear) m_acc = '0;
              else if (load) m_acc = num1;
              else if (start) begin
                m_op = int'(op);
                m_b = num2;
                m_left = (op == 3'd6 && MULT) ? W : 1;
              end
            end
            2: begin
              m_left = m_left - 1;
              if (m_left == 0) begin
                eval(m_op, m_acc, m_b, r, e);
                m_acc = r;
                m_done = !e;
              end
            end
            3: if (clear) m_acc = '0;
            default: ;
          endcase
        end
        m_state = ns;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cmp("acc", 32'(acc), 32'(m_acc));
      cmp("busy", 32'(busy), 32'(m_state == 2));
      cmp("done", 32'(done), 32'(m_done));
      cmp("ovf", 32'(ovf), 32'(m_state == 3));
      cmp("state", 32'(state), 32'(m_state));
      cmp("next_state", 32'(next_state), 32'(exp_next()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; num1 = v;
    @(negedge clk);
    load = 1'b0; num1 = W'($urandom);
  endtask

  // Returns at the negedge after the accepting edge (state = RUN).
  task automatic do_start(input logic [2:0] o, input logic [W-1:0] v);
    start = 1'b1; op = o; num2 = v;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); num2 = W'($urandom);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; on = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0;
    op = '0; num1 = '0; num2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("rst_state", 32'(state), 32'd0);
    cmp("rst_acc", 32'(acc), 32'd0);
    cmp("rst_ovf", 32'(ovf), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);

    on = 1'b1;
    @(negedge clk);
    cmp("on_ready", 32'(state), 32'd1);
    cmp("on_acc", 32'(acc), 32'd0);

    // ADD without carry
    do_load(8'h0C);
    do_start(3'd4, 8'h05);
    cmp("add_busy", 32'(busy), 32'd1);
    @(negedge clk);
    cmp("add_acc", 32'(acc), 32'h11);
    cmp("add_done", 32'(done), 32'd1);
    cmp("add_state", 32'(state), 32'd1);
    cmp("model_add_acc", 32'(m_acc), 32'h11);

    // ADD with carry -> ERROR, start ignored, clear exits
    do_load(8'd200);
    do_start(3'd4, 8'd100);
    @(negedge clk);
    cmp("addc_acc", 32'(acc), 32'd44);
    cmp("addc_ovf", 32'(ovf), 32'd1);
    cmp("addc_state", 32'(state), 32'd3);
    cmp("addc_done", 32'(done), 32'd0);
    start = 1'b1; op = 3'd7; num2 = 8'd9;
    @(negedge clk);
    start = 1'b0;
    cmp("err_start_ign", 32'(state), 32'd3);
    cmp("err_acc_hold", 32'(acc), 32'd44);
    do_clear();
    cmp("clr_state", 32'(state), 32'd1);
    cmp("clr_acc", 32'(acc), 32'd0);
    cmp("clr_ovf", 32'(ovf), 32'd0);

`ifdef ALU_MULT_EN
    do_load(8'd13);
    do_start(3'd6, 8'd11);
    for (int i = 0; i < W; i++) begin
      cmp("mul_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    cmp("mul_acc", 32'(acc), 32'd143);
    cmp("mul_done", 32'(done), 32'd1);
    cmp("mul_ovf", 32'(ovf), 32'd0);
    cmp("mul_state", 32'(state), 32'd1);
    do_start(3'd6, 8'd2);          // back-to-back in the done cycle
    repeat (W) @(negedge clk);
    cmp("mulo_acc", 32'(acc), 32'd30);
    cmp("mulo_ovf", 32'(ovf), 32'd1);
    cmp("mulo_state", 32'(state), 32'd3);
    do_clear();
`else
    do_load(8'd7);
    do_start(3'd6, 8'd3);
    @(negedge clk);
    cmp("nomul_acc", 32'(acc), 32'd7);
    cmp("nomul_ovf", 32'(ovf), 32'd1);
    cmp("nomul_state", 32'(state), 32'd3);
    do_clear();
`endif

    // SUB with borrow
    do_load(8'd3);
    do_start(3'd5, 8'd5);
    @(negedge clk);
    cmp("sub_acc", 32'(acc), 32'hFE);
    cmp("sub_state", 32'(state), 32'd3);
    cmp("sub_done", 32'(done), 32'd0);
    do_clear();

    // Power drop while RUN
    do_load(8'd13);
    do_start(3'd6, 8'd11);
    on = 1'b0;
    @(negedge clk);
    cmp("off_state", 32'(state), 32'd0);
    cmp("off_acc", 32'(acc), 32'd0);
    cmp("off_done", 32'(done), 32'd0);
    on = 1'b1;
    @(negedge clk);
    cmp("off_done2", 32'(done), 32'd0);
    cmp("off_ready", 32'(state), 32'd1);

    // Asynchronous reset while RUN
    do_load(8'd5);
    do_start(3'd6, 8'd9);
    #2 rst = 1'b1;
    #1;
    cmp("arst_state", 32'(state), 32'd0);
    cmp("arst_acc", 32'(acc), 32'd0);
    cmp("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      on    = (($urandom % 40) != 0);
      clear = (($urandom % 8) == 0);
      load  = (($urandom % 4) == 0);
      start = (($urandom % 3) == 0);
      op    = 3'($urandom);
      num1  = W'($urandom);
      num2  = (($urandom % 4) == 0) ? W'($urandom % 4) : W'($urandom);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
